// File: rtl/boton_eventos_ers.sv
// Push-button event detector: turns a debounced level into registered press,
// release and long-press pulses, a holding level and a wrapping press counter.
module boton_eventos_ers #(
    parameter int unsigned LONG_CYCLES = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pb_clean,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic             holding,
    output logic [CNT_W-1:0] press_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESSED,
        S_LONG
    } state_t;

    localparam logic [15:0] LONG_LAST = 16'(LONG_CYCLES - 1);

    state_t           state_q, state_d;
    logic [15:0]      timer_q, timer_d;
    logic [CNT_W-1:0] press_count_q, press_count_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;
    logic             long_pulse_q, long_pulse_d;
    logic             holding_q, holding_d;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        press_count_d   = press_count_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_pulse_d    = 1'b0;

        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (pb_clean) begin
                        state_d       = S_PRESSED;
                        timer_d       = 16'd0;
                        press_count_d = press_count_q + CNT_W'(1);
                        press_pulse_d = 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (!pb_clean) begin
                        state_d         = S_IDLE;
                        timer_d         = 16'd0;
                        release_pulse_d = 1'b1;
                    end else if (timer_q == LONG_LAST) begin
                        state_d      = S_LONG;
                        long_pulse_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                S_LONG: begin
                    if (!pb_clean) begin
                        state_d         = S_IDLE;
                        timer_d         = 16'd0;
                        release_pulse_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    timer_d = 16'd0;
                end
            endcase
        end

        // Disabled edges keep the state, so holding simply follows it.
        holding_d = (state_d == S_LONG);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            timer_q         <= 16'd0;
            press_count_q   <= '0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
            holding_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            press_count_q   <= press_count_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_pulse_q    <= long_pulse_d;
            holding_q       <= holding_d;
        end
    end

    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_pulse    = long_pulse_q;
    assign holding       = holding_q;
    assign press_count   = press_count_q;

endmodule

// File: tb/tb_boton_eventos_ers.sv
// Scoreboard bench for boton_eventos_ers (LONG_CYCLES=4, CNT_W=2): the driver
// queues the expected output for each cycle, a monitor pops and compares.
module tb_boton_eventos_ers;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       pb_clean;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic       holding;
    logic [1:0] press_count;

    boton_eventos_ers #(
        .LONG_CYCLES(4),
        .CNT_W      (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pb_clean     (pb_clean),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .holding      (holding),
        .press_count  (press_count)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [5:0]  vec;   // {press, release, long, holding, count[1:0]}
    } exp_t;

    exp_t exp_q[$];
    int   cycle_cnt  = 0;
    int   num_checks = 0;
    int   num_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt = cycle_cnt + 1;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] expv);
        num_checks = num_checks + 1;
        if (act !== expv) begin
            num_errors = num_errors + 1;
            $display("FAIL %s: got {pp,rp,lp,hold,cnt}=%b, expected %b", name, act, expv);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cycle_cnt) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("cycle%0d", e.cyc),
                  {press_pulse, release_pulse, long_pulse, holding, press_count},
                  e.vec);
        end
    end

    task automatic push_exp(input logic pp, input logic rp, input logic lp,
                            input logic hold, input logic [1:0] cnt);
        exp_t e;
        e.cyc = 32'(cycle_cnt + 1);
        e.vec = {pp, rp, lp, hold, cnt};
        exp_q.push_back(e);
    endtask

    // Drive inputs for the next rising edge and queue the outputs expected after it.
    task automatic step(input logic rst, input logic en, input logic pb,
                        input logic pp, input logic rp, input logic lp,
                        input logic hold, input logic [1:0] cnt);
        @(negedge clk);
        #1;
        reset    = rst;
        enable   = en;
        pb_clean = pb;
        push_exp(pp, rp, lp, hold, cnt);
    endtask

    // Short reset pulse entirely inside the low clock phase: only an
    // asynchronous reset can see it.
    task automatic glitch_reset(input logic pp, input logic [1:0] cnt);
        @(negedge clk);
        #1;
        reset    = 1'b0;
        enable   = 1'b1;
        pb_clean = 1'b1;
        push_exp(pp, 1'b0, 1'b0, 1'b0, cnt);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        enable   = 1'b1;
        pb_clean = 1'b1;

        // Held reset with button down: everything stays zero.
        repeat (3) step(0, 1, 1, 0, 0, 0, 0, 2'd0);
        // First edge after release counts the press.
        step(1, 1, 1, 1, 0, 0, 0, 2'd1);
        // Single-sample press: release on the very next sample.
        step(1, 1, 0, 0, 1, 0, 0, 2'd1);
        step(1, 1, 0, 0, 0, 0, 0, 2'd1);

        // Ten samples high, then release: long at the 5th, holding until release.
        step(1, 1, 1, 1, 0, 0, 0, 2'd2);
        repeat (3) step(1, 1, 1, 0, 0, 0, 0, 2'd2);
        step(1, 1, 1, 0, 0, 1, 1, 2'd2);
        repeat (5) step(1, 1, 1, 0, 0, 0, 1, 2'd2);
        step(1, 1, 0, 0, 1, 0, 0, 2'd2);

        // Short press: three samples, no long event.
        step(1, 1, 1, 1, 0, 0, 0, 2'd3);
        repeat (2) step(1, 1, 1, 0, 0, 0, 0, 2'd3);
        step(1, 1, 0, 0, 1, 0, 0, 2'd3);

        // Enable toggling: count wraps 3 -> 0, timer moves only on enabled edges.
        step(1, 1, 1, 1, 0, 0, 0, 2'd0);
        step(1, 0, 1, 0, 0, 0, 0, 2'd0);
        repeat (3) begin
            step(1, 1, 1, 0, 0, 0, 0, 2'd0);
            step(1, 0, 1, 0, 0, 0, 0, 2'd0);
        end
        step(1, 1, 1, 0, 0, 1, 1, 2'd0);
        step(1, 0, 1, 0, 0, 0, 1, 2'd0);
        step(1, 1, 1, 0, 0, 0, 1, 2'd0);
        // Disabled sample of a low button is ignored; enabled one releases.
        step(1, 0, 0, 0, 0, 0, 1, 2'd0);
        step(1, 1, 0, 0, 1, 0, 0, 2'd0);

        // Fifth press, up to holding.
        step(1, 1, 1, 1, 0, 0, 0, 2'd1);
        repeat (3) step(1, 1, 1, 0, 0, 0, 0, 2'd1);
        step(1, 1, 1, 0, 0, 1, 1, 2'd1);
        step(1, 1, 1, 0, 0, 0, 1, 2'd1);

        // Reset glitch while holding: press discarded, counter cleared, new press.
        glitch_reset(1'b1, 2'd1);
        step(1, 0, 0, 0, 0, 0, 0, 2'd1);
        step(1, 1, 0, 0, 1, 0, 0, 2'd1);

        // Held reset in mid-press: no release pulse, new press after release.
        step(1, 1, 1, 1, 0, 0, 0, 2'd2);
        repeat (2) step(0, 1, 1, 0, 0, 0, 0, 2'd0);
        step(1, 1, 1, 1, 0, 0, 0, 2'd1);
        step(1, 1, 0, 0, 1, 0, 0, 2'd1);
        step(1, 1, 0, 0, 0, 0, 0, 2'd1);

        begin
            int waited;
            waited = 0;
            while (exp_q.size() > 0 && waited < 20) begin
                @(negedge clk);
                waited = waited + 1;
            end
            if (exp_q.size() > 0) begin
                num_checks = num_checks + 1;
                num_errors = num_errors + 1;
                $display("FAIL drain: %0d expected entries left unchecked, expected 0", exp_q.size());
            end
        end

        #2;
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/boton_eventos_ers.md
BOTON_EVENTOS_ERS -- requirements
Module: boton_eventos_ers

Interface
REQ-001 Parameter LONG_CYCLES, default 16: number of enabled samples with pb_clean held high, after the press sample, that makes a long press; legal range 2..2^16-1.
REQ-002 Parameter CNT_W, default 8: width of press_count.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; reset=0 forces the reset state immediately.
REQ-005 enable  in  1  sample qualifier; pb_clean is sampled only on edges where enable=1.
REQ-006 pb_clean  in  1  debounced push-button level from the upstream debounce register; 1 = pressed.
REQ-007 press_pulse  out  1  one-cycle pulse on each press.
REQ-008 release_pulse  out  1  one-cycle pulse on each release.
REQ-009 long_pulse  out  1  one-cycle pulse when a press reaches LONG_CYCLES.
REQ-010 holding  out  1  level; 1 while in state LONG.
REQ-011 press_count  out  CNT_W  number of presses since reset, modulo 2^CNT_W.

Function
REQ-012 Internal FSM with states IDLE, PRESSED, LONG, and a 16-bit hold timer; all outputs SHALL be registered.
REQ-013 Edge with enable=0: state, timer and press_count hold; press_pulse, release_pulse and long_pulse are 0 on the following cycle.
REQ-014 IDLE, enable=1, pb_clean=1: go to PRESSED; timer <= 0; press_count <= press_count+1; press_pulse=1 for the next cycle.
REQ-015 IDLE, enable=1, pb_clean=0: remain in IDLE; no pulses.
REQ-016 PRESSED, enable=1, pb_clean=1, timer < LONG_CYCLES-1: timer <= timer+1; remain in PRESSED.
REQ-017 PRESSED, enable=1, pb_clean=1, timer == LONG_CYCLES-1: go to LONG; long_pulse=1 for the next cycle; timer holds.
REQ-018 PRESSED or LONG, enable=1, pb_clean=0: go to IDLE; release_pulse=1 for the next cycle; timer <= 0.
REQ-019 LONG, enable=1, pb_clean=1: remain in LONG; no further long_pulse until a new press occurs.
REQ-020 Latency: each pulse is visible in the clock cycle immediately after the sampling edge that caused it, and is high for exactly one clk period.
REQ-021 At most one of press_pulse, release_pulse and long_pulse SHALL be 1 in any cycle.
REQ-022 press_count wraps from 2^CNT_W-1 to 0 on the next press, with no saturation and no flag.
REQ-023 holding SHALL be 1 exactly in the cycles after an edge that enters or stays in LONG, and 0 from the cycle after the release edge.
REQ-024 A single enabled sample of pb_clean=1 between 0 samples SHALL produce press_pulse, then release_pulse on the next enabled sample; the block adds no filtering of its own.

Reset
REQ-025 While reset=0, regardless of clk: state=IDLE, timer=0, press_count=0, and press_pulse=release_pulse=long_pulse=holding=0.
REQ-026 Reset asserted mid-press (PRESSED or LONG) SHALL discard the press with no release_pulse; after reset is released with pb_clean=1, the first enabled sample SHALL count as a new press.
REQ-027 Reset release is synchronous to clk in the system; the first edge after release evaluates normally.

Verification
REQ-028 reset=0 for 3 cycles with pb_clean=1 and enable=1 -> all outputs 0 during reset; press_pulse=1 one cycle after the first edge following release; press_count=1.
REQ-029 LONG_CYCLES=4, enable=1, pb_clean=1 for 10 cycles then 0 -> press_pulse at cycle 1, long_pulse at cycle 5, holding=1 from cycle 5 until release, release_pulse one cycle after pb_clean falls.
REQ-030 LONG_CYCLES=4, pb_clean=1 for 3 samples then 0 -> press_pulse and release_pulse only; long_pulse and holding stay 0.
REQ-031 enable toggling 1/0 every cycle during a press -> the timer advances only on enabled edges; long_pulse at the 4th enabled sample after the press (LONG_CYCLES=4); all pulses one cycle wide.
REQ-032 CNT_W=2, five separate presses -> press_count sequence 1,2,3,0,1.
REQ-033 reset pulsed low while holding=1 -> outputs cleared asynchronously with no release_pulse; press_count=0, then 1 on the next enabled sample with pb_clean=1.
